// File: rtl/linear_led_streamer_if.sv
// LED beat stream between linear_led_streamer and the LED driver.
// The master presents one colour per physical LED. A beat moves on
// led_v & led_rdy.
//   led_v      master -> slave  beat valid
//   led_rgb    master -> slave  beat colour (GRB packed)
//   led_idx    master -> slave  physical LED index of the beat
//   frame_last master -> slave  final beat of the frame
//   led_rdy    slave  -> master driver can accept a beat
interface linear_led_streamer_if #(
  parameter int COLOR_W = 24,
  parameter int CNT_W   = 6
);
  logic               led_v;
  logic [COLOR_W-1:0] led_rgb;
  logic [CNT_W-1:0]   led_idx;
  logic               frame_last;
  logic               led_rdy;

  modport master (output led_v, led_rgb, led_idx, frame_last, input led_rdy);
  modport slave  (input led_v, led_rgb, led_idx, frame_last, output led_rdy);
endinterface

// File: rtl/linear_led_streamer.sv
// Back end of the linear visualizer. On an accepted start it snapshots the
// per-bin colours and LED counts. It then streams exactly LEDS beats, one
// colour per physical LED, bin by bin, with a rotation offset applied to the
// physical index. Frames whose counts sum to less than LEDS are padded with
// black. Frames whose counts sum to more than LEDS are truncated, and
// overflow is raised.
//   clk, rst    clock and synchronous active-high reset
//   start       frame request; only acted on in IDLE
//   rgb         per-bin colour, captured on accepted start
//   led_counts  per-bin LED count, captured on accepted start
//   rotate      physical offset of logical LED 0, captured on accepted start
//   led         beat stream (master side)
//   busy        high whenever not IDLE
//   done        one-cycle pulse after the last beat is accepted
//   overflow    the current or last frame's counts sum to more than LEDS
//   missed      one-cycle pulse: start was seen while not IDLE
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | building the saturated prefix sums from the snapshot
// STREAM | presenting beats; the first cycle only primes beat 0
// DONE   | done pulse, then back to IDLE
module linear_led_streamer #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int COLOR_W = 24,
  parameter int CNT_W   = $clog2(LEDS + 1),
  parameter int ROT_EN  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [BIN_QTY-1:0][COLOR_W-1:0]   rgb,
  input  logic [BIN_QTY-1:0][CNT_W-1:0]     led_counts,
  input  logic [CNT_W-1:0]                  rotate,
  linear_led_streamer_if.master             led,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic                              missed
);

  localparam int SUM_W = CNT_W + $clog2(BIN_QTY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t                            state;
  logic [BIN_QTY-1:0][COLOR_W-1:0]   rgb_q;
  logic [BIN_QTY-1:0][CNT_W-1:0]     cnt_q;
  logic [BIN_QTY-1:0][CNT_W-1:0]     pfx_q;
  logic [CNT_W-1:0]                  rot_q;
  logic [CNT_W-1:0]                  k_q;

  logic [BIN_QTY-1:0][CNT_W-1:0]     pfx_c;
  logic [SUM_W-1:0]                  run_sum;
  logic [SUM_W-1:0]                  total;
  logic [CNT_W-1:0]                  k_nxt;
  logic [COLOR_W-1:0]                col_nxt;
  logic [CNT_W:0]                    idx_sum;
  logic [CNT_W-1:0]                  idx_nxt;
  logic                              last_nxt;

  // Saturating prefix sums of the snapshot counts. The running sum is wide
  // enough that it can never wrap.
  always_comb begin
    run_sum = '0;
    pfx_c   = '0;
    for (int b = 0; b < BIN_QTY; b++) begin
      run_sum  = run_sum + SUM_W'(cnt_q[b]);
      pfx_c[b] = (run_sum > SUM_W'(LEDS)) ? CNT_W'(LEDS) : run_sum[CNT_W-1:0];
    end
    total = run_sum;
  end

  // Next beat to present. While led_v is low (priming cycle), the next beat
  // is beat 0; after that, each transfer advances k.
  always_comb begin
    k_nxt   = led.led_v ? k_q + CNT_W'(1) : '0;
    col_nxt = '0;
    // Scan from the top down so that the lowest matching bin wins.
    // Zero-count bins repeat the previous prefix and never match first.
    for (int b = BIN_QTY - 1; b >= 0; b--) begin
      if (k_nxt < pfx_q[b]) col_nxt = rgb_q[b];
    end
    idx_sum = {1'b0, k_nxt} + {1'b0, rot_q};
    if (idx_sum >= (CNT_W + 1)'(LEDS)) idx_sum = idx_sum - (CNT_W + 1)'(LEDS);
    idx_nxt  = idx_sum[CNT_W-1:0];
    last_nxt = (k_nxt == CNT_W'(LEDS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rgb_q          <= '0;
      cnt_q          <= '0;
      pfx_q          <= '0;
      rot_q          <= '0;
      k_q            <= '0;
      led.led_v      <= 1'b0;
      led.led_rgb    <= '0;
      led.led_idx    <= '0;
      led.frame_last <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      missed         <= 1'b0;
    end else begin
      missed <= start && (state != S_IDLE);
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rgb_q    <= rgb;
            cnt_q    <= led_counts;
            // An out-of-range rotation is treated as no rotation.
            rot_q    <= (ROT_EN != 0 && rotate < CNT_W'(LEDS)) ? rotate : '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          pfx_q    <= pfx_c;
          overflow <= (total > SUM_W'(LEDS));
          state    <= S_STREAM;
        end
        S_STREAM: begin
          if (!led.led_v || led.led_rdy) begin
            if (led.led_v && led.frame_last) begin
              led.led_v      <= 1'b0;
              led.led_rgb    <= '0;
              led.led_idx    <= '0;
              led.frame_last <= 1'b0;
              done           <= 1'b1;
              state          <= S_DONE;
            end else begin
              led.led_v      <= 1'b1;
              led.led_rgb    <= col_nxt;
              led.led_idx    <= idx_nxt;
              led.frame_last <= last_nxt;
              k_q            <= k_nxt;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_led_streamer.sv
// Directed bench for linear_led_streamer. There are three instances:
//   dut1 LEDS=8,  BIN_QTY=4,  ROT_EN=1 (main target, ready driven by the bench)
//   dut2 LEDS=8,  BIN_QTY=4,  ROT_EN=0 (shares dut1 inputs, ready tied high)
//   dut3 LEDS=50, BIN_QTY=12, ROT_EN=1 (full-size frames, ready tied high)
module tb_linear_led_streamer;

  localparam logic [23:0] A = 24'h112233;
  localparam logic [23:0] B = 24'h445566;
  localparam logic [23:0] C = 24'h778899;
  localparam logic [23:0] D = 24'hAABBCC;

  typedef logic [23:0] rgb8_t [8];
  typedef int          idx8_t [8];

  logic clk, rst, start, start3;
  logic [3:0][23:0]  rgb;
  logic [3:0][3:0]   counts;
  logic [3:0]        rotate;
  logic [11:0][23:0] rgb50;
  logic [11:0][5:0]  counts50;
  logic [5:0]        rotate50;
  logic busy1, done1, ovf1, miss1;
  logic busy2, done2, ovf2, miss2;
  logic busy3, done3, ovf3, miss3;

  linear_led_streamer_if #(.COLOR_W(24), .CNT_W(4)) led1 ();
  linear_led_streamer_if #(.COLOR_W(24), .CNT_W(4)) led2 ();
  linear_led_streamer_if #(.COLOR_W(24), .CNT_W(6)) led3 ();

  assign led2.led_rdy = 1'b1;
  assign led3.led_rdy = 1'b1;

  linear_led_streamer #(.LEDS(8), .BIN_QTY(4), .COLOR_W(24), .CNT_W(4), .ROT_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .rgb(rgb), .led_counts(counts), .rotate(rotate),
    .led(led1), .busy(busy1), .done(done1), .overflow(ovf1), .missed(miss1));

  linear_led_streamer #(.LEDS(8), .BIN_QTY(4), .COLOR_W(24), .CNT_W(4), .ROT_EN(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .rgb(rgb), .led_counts(counts), .rotate(rotate),
    .led(led2), .busy(busy2), .done(done2), .overflow(ovf2), .missed(miss2));

  linear_led_streamer #(.LEDS(50), .BIN_QTY(12), .COLOR_W(24), .CNT_W(6), .ROT_EN(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .rgb(rgb50), .led_counts(counts50), .rotate(rotate50),
    .led(led3), .busy(busy3), .done(done3), .overflow(ovf3), .missed(miss3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [23:0] got_rgb  [16];
  logic [3:0]  got_idx  [16];
  logic        got_last [16];
  logic [3:0]  got2_idx [16];
  int nb, nb2, done_cyc;
  logic ovf_at_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c0, input int c1, input int c2, input int c3, input int rot);
    counts[0] = 4'(c0);
    counts[1] = 4'(c1);
    counts[2] = 4'(c2);
    counts[3] = 4'(c3);
    rotate    = 4'(rot);
  endtask

  // The first step lets a finishing frame pass DONE. Start is then sampled
  // at edge t. The task returns just after edge t (cycle 0).
  task automatic start_frame();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs from cycle 0 until done is seen or the budget runs out.
  // When miss_at >= 0, start is pulsed with different inputs at that cycle.
  task automatic collect(input int budget, input bit rnd, input int miss_at);
    logic [23:0] s_rgb;
    logic [3:0]  s_idx;
    logic        s_last;
    bit          stalled;
    nb = 0;
    nb2 = 0;
    done_cyc = -1;
    stalled = 1'b0;
    s_rgb = '0;
    s_idx = '0;
    s_last = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (stalled) begin
        chk("stall_rgb", led1.led_rgb, s_rgb);
        chk("stall_idx", led1.led_idx, s_idx);
        chk("stall_last", led1.frame_last, s_last);
      end
      stalled = 1'b0;
      if (cyc == miss_at) begin
        start = 1'b1;
        counts[0] = 4'd1;
        counts[1] = 4'd1;
        counts[2] = 4'd1;
        counts[3] = 4'd1;
        rotate = 4'd5;
      end
      if (miss_at >= 0 && cyc == miss_at + 1) begin
        start = 1'b0;
        chk("missed_pulse", miss1, 1);
      end
      if (cyc == 1) chk("missed_quiet", miss1, 0);
      led1.led_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (led1.led_v) begin
        if (led1.led_rdy) begin
          if (nb < 16) begin
            got_rgb[nb]  = led1.led_rgb;
            got_idx[nb]  = led1.led_idx;
            got_last[nb] = led1.frame_last;
          end
          nb++;
        end else begin
          stalled = 1'b1;
          s_rgb  = led1.led_rgb;
          s_idx  = led1.led_idx;
          s_last = led1.frame_last;
        end
      end
      if (led2.led_v) begin
        if (nb2 < 16) got2_idx[nb2] = led2.led_idx;
        nb2++;
      end
      if (done1) begin
        done_cyc = cyc;
        ovf_at_done = ovf1;
        break;
      end
      step();
    end
    led1.led_rdy = 1'b1;
  endtask

  task automatic check_frame(input string tag, input rgb8_t er, input idx8_t ei, input int exp_done);
    chk({tag, "_beats"}, nb, 8);
    if (exp_done >= 0) chk({tag, "_done_cyc"}, done_cyc, exp_done);
    else chk({tag, "_done_seen"}, done_cyc >= 0, 1);
    for (int k = 0; k < 8 && k < nb; k++) begin
      chk($sformatf("%s_rgb[%0d]", tag, k), got_rgb[k], er[k]);
      chk($sformatf("%s_idx[%0d]", tag, k), got_idx[k], ei[k]);
      chk($sformatf("%s_last[%0d]", tag, k), got_last[k], k == 7);
    end
  endtask

  initial begin
    rgb8_t e1, e2, eA;
    idx8_t i0, i3;
    int done_seen;
    int nb3;
    e1 = '{A, A, B, B, B, D, 24'h0, 24'h0};
    e2 = '{A, A, A, A, B, B, B, B};
    eA = '{A, A, A, A, A, A, A, A};
    i0 = '{0, 1, 2, 3, 4, 5, 6, 7};
    i3 = '{3, 4, 5, 6, 7, 0, 1, 2};

    rst = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    rgb[0] = A; rgb[1] = B; rgb[2] = C; rgb[3] = D;
    set_cfg(0, 0, 0, 0, 0);
    rgb50 = '0;
    counts50 = '0;
    rotate50 = '0;
    led1.led_rdy = 1'b1;
    repeat (2) step();
    chk("rst_v", led1.led_v, 0);
    chk("rst_rgb", led1.led_rgb, 0);
    chk("rst_last", led1.frame_last, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_ovf", ovf1, 0);
    rst = 1'b0;

    // Case 1: mixed counts with a zero bin and black padding.
    set_cfg(2, 3, 0, 1, 0);
    start_frame();
    chk("c1_busy_c0", busy1, 1);
    collect(40, 1'b0, -1);
    check_frame("c1", e1, i0, 10);
    chk("c1_ovf", ovf_at_done, 0);
    step();
    chk("c1_busy_end", busy1, 0);

    // Case 2: the counts overflow; the third bin is truncated away.
    set_cfg(4, 4, 4, 0, 0);
    start_frame();
    collect(40, 1'b0, -1);
    check_frame("c2", e2, i0, 10);
    chk("c2_ovf_done", ovf_at_done, 1);
    repeat (3) step();
    chk("c2_ovf_hold", ovf1, 1);

    // Case 3: rotation. rot=3 wraps the index, rot=9 is out of range, and
    // ROT_EN=0 ignores rotate.
    set_cfg(8, 0, 0, 0, 3);
    start_frame();
    chk("c3_ovf_cleared", ovf1, 0);
    collect(40, 1'b0, -1);
    check_frame("c3r3", eA, i3, 10);
    chk("c3_noen_beats", nb2, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("c3_noen_idx[%0d]", k), got2_idx[k], k);
    set_cfg(8, 0, 0, 0, 9);
    start_frame();
    collect(40, 1'b0, -1);
    check_frame("c3r9", eA, i0, 10);

    // Case 4: random backpressure.
    set_cfg(2, 3, 0, 1, 0);
    start_frame();
    collect(300, 1'b1, -1);
    check_frame("c4", e1, i0, -1);

    // Case 5a: start mid-stream is ignored and pulses missed.
    set_cfg(2, 3, 0, 1, 0);
    start_frame();
    collect(40, 1'b0, 4);
    check_frame("c5a", e1, i0, 10);

    // Case 5b: reset while beat 4 is presented.
    set_cfg(4, 4, 4, 0, 0);
    start_frame();
    repeat (6) step();
    chk("c5b_v_pre", led1.led_v, 1);
    chk("c5b_rgb_pre", led1.led_rgb, B);
    chk("c5b_ovf_pre", ovf1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("c5b_v", led1.led_v, 0);
    chk("c5b_rgb", led1.led_rgb, 0);
    chk("c5b_idx", led1.led_idx, 0);
    chk("c5b_last", led1.frame_last, 0);
    chk("c5b_busy", busy1, 0);
    chk("c5b_done", done1, 0);
    chk("c5b_ovf", ovf1, 0);
    chk("c5b_miss", miss1, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done1) done_seen++;
    end
    chk("c5b_no_done", done_seen, 0);
    set_cfg(2, 3, 0, 1, 0);
    start_frame();
    collect(40, 1'b0, -1);
    check_frame("c5b_after", e1, i0, 10);

    // Case 6: full-size instance with all-zero counts, then all-full counts.
    for (int b = 0; b < 12; b++) rgb50[b] = 24'h100000 + 24'(b);
    counts50 = '0;
    step();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    nb3 = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (led3.led_v) begin
        chk($sformatf("c6z_rgb[%0d]", nb3), led3.led_rgb, 0);
        chk($sformatf("c6z_idx[%0d]", nb3), led3.led_idx, nb3);
        nb3++;
      end
      if (done3) begin
        done_seen = 1;
        break;
      end
      step();
    end
    chk("c6z_done", done_seen, 1);
    chk("c6z_beats", nb3, 50);
    chk("c6z_ovf", ovf3, 0);

    for (int b = 0; b < 12; b++) counts50[b] = 6'd50;
    step();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    nb3 = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (led3.led_v) begin
        chk($sformatf("c6f_rgb[%0d]", nb3), led3.led_rgb, 24'h100000);
        nb3++;
      end
      if (done3) begin
        done_seen = 1;
        break;
      end
      step();
    end
    chk("c6f_done", done_seen, 1);
    chk("c6f_beats", nb3, 50);
    chk("c6f_ovf", ovf3, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
